// File: rtl/mem_pkg.sv
// Shared types and width constants for the latency-modelled data memory.
package mem_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned BYTES_W = WORD_W / 8;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables/data replication and load
// byte/half extraction with sign or zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]         funct3,
  input  logic [1:0]         addr_lo,
  input  logic [WORD_W-1:0]  wdata,
  input  logic [WORD_W-1:0]  rword,
  output logic [BYTES_W-1:0] wbe,
  output logic [WORD_W-1:0]  wdata_sh,
  output logic [WORD_W-1:0]  rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rword[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? rword[31:16] : rword[15:0];
    wbe       = '0;
    wdata_sh  = '0;
    rdata_ext = '0;
    // Store data is replicated across lanes so only the enables pick the slot.
    case (funct3)
      F3_B, F3_BU: begin
        wbe       = 4'b0001 << addr_lo;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                     : {24'b0, byte_sel};
      end
      F3_H, F3_HU: begin
        wbe       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                     : {16'b0, half_sel};
      end
      F3_W: begin
        wbe       = '1;
        wdata_sh  = wdata;
        rdata_ext = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_latency.sv
// Single-outstanding data memory with fixed read/write latency and RV32I sizing.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned H/HU/W instead of aligning down.
module data_memory_latency
  import mem_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS    = 128,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  state_e              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;

  logic [WORD_W-1:0]   mem_q [NUM_BLOCKS];

  logic                acc_we;
  logic [2:0]          acc_f3;
  logic [ADDR_W-1:0]   acc_addr;
  logic [WORD_W-1:0]   acc_wdata;
  logic [IDX_W-1:0]    acc_idx;
  logic                oob, f3_bad, mis, acc_err;
  logic [WORD_W-1:0]   rword;
  logic [BYTES_W-1:0]  wbe;
  logic [WORD_W-1:0]   wdata_sh, rdata_ext;
  logic [31:0]         lat_in;
  logic                go_resp, mem_wr;

  // With latency 1 the access happens on the acceptance edge itself, so the
  // access path takes live request fields in IDLE and captured ones otherwise.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we    = req_we;
      acc_f3    = req_funct3;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_f3    = f3_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
    acc_idx = acc_addr[IDX_W+1:2];
    oob     = 32'(acc_addr[ADDR_W-1:2]) >= 32'(NUM_BLOCKS);
    case (acc_f3)
      F3_B, F3_H, F3_W: f3_bad = 1'b0;
      F3_BU, F3_HU:     f3_bad = acc_we;
      default:          f3_bad = 1'b1;
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (((acc_f3 == F3_H) || (acc_f3 == F3_HU)) && acc_addr[0]) ||
          ((acc_f3 == F3_W) && (acc_addr[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
    acc_err = oob | f3_bad | mis;
    rword   = oob ? '0 : mem_q[acc_idx];
  end

  mem_lane_align u_align (
    .funct3    (acc_f3),
    .addr_lo   (acc_addr[1:0]),
    .wdata     (acc_wdata),
    .rword     (rword),
    .wbe       (wbe),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  always_comb begin
    lat_in  = req_we ? 32'(WRITE_LATENCY) : 32'(READ_LATENCY);
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    go_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (lat_in > 32'd1) begin
            state_d = S_WAIT;
            cnt_d   = lat_in - 32'd2;
          end else begin
            go_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) go_resp = 1'b1;
        else             cnt_d   = cnt_q - 32'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (go_resp) begin
      state_d = S_RESP;
      valid_d = 1'b1;
      err_d   = acc_err;
      rdata_d = (acc_we || acc_err) ? '0 : rdata_ext;
    end
    ready_d = (state_d == S_IDLE);
    mem_wr  = go_resp && acc_we && !acc_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is never cleared; holding reset low suppresses any store.
  always_ff @(posedge clk) begin
    if (mem_wr && rst) begin
      for (int unsigned b = 0; b < BYTES_W; b++) begin
        if (wbe[b]) mem_q[acc_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_memory_latency.sv
// Directed scoreboard bench: instance A (RL=2, WL=1) for data paths, instance B
// (RL=1, WL=3) for the latency-1 read path and mid-WAIT reset abort.
module tb_data_memory_latency;

  localparam int unsigned A_RL = 2, A_WL = 1, B_RL = 1, B_WL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;

  logic        a_ready, a_valid, a_err, b_ready, b_valid, b_err;
  logic [31:0] a_rdata, b_rdata;

  bit          sel = 1'b0;
  logic        o_ready, o_valid, o_err;
  logic [31:0] o_rdata;

  always_comb begin
    o_ready = sel ? b_ready : a_ready;
    o_valid = sel ? b_valid : a_valid;
    o_err   = sel ? b_err   : a_err;
    o_rdata = sel ? b_rdata : a_rdata;
  end

  data_memory_latency #(.NUM_BLOCKS(128), .READ_LATENCY(A_RL), .WRITE_LATENCY(A_WL)) dut_a (
    .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(a_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_valid), .rsp_rdata(a_rdata), .rsp_err(a_err));

  data_memory_latency #(.NUM_BLOCKS(16), .READ_LATENCY(B_RL), .WRITE_LATENCY(B_WL)) dut_b (
    .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(b_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_valid), .rsp_rdata(b_rdata), .rsp_err(b_err));

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Caller is positioned at a negedge; returns at a negedge one cycle after the response.
  task automatic do_req(input bit s, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    int   n;
    int   k;
    bit   got;
    exp_t e;
    sel = s;
    n = 0;
    while (o_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(o_ready), 32'd1);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    valid_a    = !s;
    valid_b    = s;
    sb.push_back('{tag, exp_rdata, exp_err,
                   s ? (we ? B_WL : B_RL) : (we ? A_WL : A_RL)});
    @(posedge clk);
    #1;
    valid_a    = 1'b0;
    valid_b    = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    k = 0;
    got = 1'b0;
    while (k < 20 && !got) begin
      @(negedge clk);
      k++;
      check({tag, "_busy"}, 32'(o_ready), 32'd0);
      if (o_valid === 1'b1) got = 1'b1;
    end
    e = sb.pop_front();
    if (!got) begin
      check({e.tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({e.tag, "_lat"}, 32'(k), 32'(e.lat));
      check({e.tag, "_rdata"}, o_rdata, e.rdata);
      check({e.tag, "_err"}, 32'(o_err), 32'(e.err));
    end
    @(negedge clk);
    check({tag, "_idle_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_idle_rdata"}, o_rdata, 32'd0);
    check({tag, "_idle_err"}, 32'(o_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks %0d, errors %0d)", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_a_ready", 32'(a_ready), 32'd1);
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_a_rdata", a_rdata, 32'd0);
    check("rst_a_err",   32'(a_err), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd1);
    check("rst_b_valid", 32'(b_valid), 32'd0);

    do_req(0, 1, 3'b010, 32'h8,   32'hDEADBEEF, 32'h0,        0, "sw_8");
    do_req(0, 0, 3'b010, 32'h8,   32'h0,        32'hDEADBEEF, 0, "lw_8");
    do_req(0, 0, 3'b000, 32'hB,   32'h0,        32'hFFFFFFDE, 0, "lb_b");
    do_req(0, 0, 3'b100, 32'hB,   32'h0,        32'h000000DE, 0, "lbu_b");
    do_req(0, 0, 3'b001, 32'h8,   32'h0,        32'hFFFFBEEF, 0, "lh_8");
    do_req(0, 0, 3'b101, 32'hA,   32'h0,        32'h0000DEAD, 0, "lhu_a");
    do_req(0, 1, 3'b000, 32'h9,   32'h12,       32'h0,        0, "sb_9");
    do_req(0, 0, 3'b010, 32'h8,   32'h0,        32'hDEAD12EF, 0, "lw_8_sb");
    do_req(0, 1, 3'b001, 32'hA,   32'h8001,     32'h0,        0, "sh_a");
    do_req(0, 0, 3'b010, 32'h8,   32'h0,        32'h800112EF, 0, "lw_8_sh");
    do_req(0, 0, 3'b001, 32'hA,   32'h0,        32'hFFFF8001, 0, "lh_a");
    do_req(0, 0, 3'b000, 32'h8,   32'h0,        32'hFFFFFFEF, 0, "lb_8");
    do_req(0, 0, 3'b100, 32'h9,   32'h0,        32'h00000012, 0, "lbu_9");
    do_req(0, 1, 3'b010, 32'h0,   32'h0BADF00D, 32'h0,        0, "sw_0");
    do_req(0, 1, 3'b010, 32'h200, 32'hFFFFFFFF, 32'h0,        1, "sw_oob");
    do_req(0, 0, 3'b010, 32'h0,   32'h0,        32'h0BADF00D, 0, "lw_0_kept");
    do_req(0, 0, 3'b010, 32'h200, 32'h0,        32'h0,        1, "lw_oob");
    do_req(0, 1, 3'b010, 32'h1FC, 32'h13579BDF, 32'h0,        0, "sw_last");
    do_req(0, 0, 3'b010, 32'h1FC, 32'h0,        32'h13579BDF, 0, "lw_last");
    do_req(0, 0, 3'b011, 32'h8,   32'h0,        32'h0,        1, "ld_bad_f3");
    do_req(0, 1, 3'b100, 32'h8,   32'h0,        32'h0,        1, "st_bad_f3");
    do_req(0, 0, 3'b010, 32'h8,   32'h0,        32'h800112EF, 0, "lw_8_kept");
    do_req(0, 1, 3'b010, 32'h4,   32'hCAFEF00D, 32'h0,        0, "sw_4");
`ifdef DMEM_MISALIGN_TRAP_EN
    do_req(0, 0, 3'b010, 32'h6,   32'h0,        32'h0,        1, "lw_6_mis");
    do_req(0, 0, 3'b101, 32'hB,   32'h0,        32'h0,        1, "lhu_b_mis");
`else
    do_req(0, 0, 3'b010, 32'h6,   32'h0,        32'hCAFEF00D, 0, "lw_6_mis");
    do_req(0, 0, 3'b101, 32'hB,   32'h0,        32'h00008001, 0, "lhu_b_mis");
`endif
    do_req(0, 1, 3'b010, 32'hC,   32'h0,        32'h0,        0, "sw_c");
    do_req(0, 1, 3'b000, 32'hC,   32'hFFFFFF77, 32'h0,        0, "sb_c");
    do_req(0, 0, 3'b010, 32'hC,   32'h0,        32'h00000077, 0, "lw_c");

    do_req(1, 1, 3'b010, 32'h10,  32'h11,       32'h0,        0, "b_sw_prior");
    do_req(1, 0, 3'b010, 32'h10,  32'h0,        32'h11,       0, "b_lw_prior");

    sel        = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    req_wdata  = 32'h55;
    valid_b    = 1'b1;
    @(posedge clk);
    #1 valid_b = 1'b0;
    @(negedge clk);
    check("b_in_wait", 32'(b_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("b_async_valid", 32'(b_valid), 32'd0);
    check("b_async_ready", 32'(b_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("b_no_rsp", 32'(b_valid), 32'd0);
    end
    do_req(1, 0, 3'b010, 32'h10,  32'h0,        32'h11,       0, "b_lw_after_abort");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_latency.md
DATA_MEMORY_LATENCY -- requirements
Module: data_memory_latency

Interface
REQ-001 Parameter NUM_BLOCKS, default 128, number of 32-bit words in the array (>= 2).
REQ-002 Parameter READ_LATENCY, default 2, cycles from read acceptance to rsp_valid (>= 1).
REQ-003 Parameter WRITE_LATENCY, default 1, cycles from write acceptance to rsp_valid (>= 1).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_funct3  input  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 rsp_valid  output  1  one-cycle response strobe.
REQ-013 rsp_rdata  output  32  load result, extended per funct3; 0 for stores and errors.
REQ-014 rsp_err  output  1  access fault, valid with rsp_valid.

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 Acceptance = req_valid && req_ready at a rising edge; request fields captured into registers then; inputs ignored afterwards.
REQ-017 IDLE -> WAIT on acceptance if latency L > 1, counter loaded with L-2; IDLE -> RESP directly if L = 1.
REQ-018 WAIT decrements each cycle; WAIT -> RESP when counter = 0.
REQ-019 RESP lasts exactly one cycle with rsp_valid = 1, then -> IDLE; rsp_valid is high exactly L cycles after the acceptance edge.
REQ-020 Throughput: one request per L+1 cycles; no overlap, no queueing.
REQ-021 Array read and byte-lane write occur on the WAIT/IDLE -> RESP edge; a store's new data is visible to every later accepted load.
REQ-022 Store lanes: SB writes byte addr[1:0], SH writes half addr[1], SW writes all 4 bytes; other bytes unchanged.
REQ-023 Load: B/H sign-extend, BU/HU zero-extend, W unchanged; byte/half selected by addr[1:0]/addr[1].
REQ-024 Word index = addr[31:2]; index >= NUM_BLOCKS -> rsp_err = 1, no write, rsp_rdata = 0.
REQ-025 funct3 not in the listed set (or 1xx on a store) -> rsp_err = 1, no write, rsp_rdata = 0.
REQ-026 rsp_rdata and rsp_err are 0 whenever rsp_valid = 0.

Reset
REQ-027 rst low asynchronously forces IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 1 after release.
REQ-028 Reset mid-operation aborts the request; a pending store is not written; array contents are not cleared.

Configuration
REQ-029 Macro DMEM_MISALIGN_TRAP_EN defined: H/HU with addr[0] = 1 or W with addr[1:0] != 0 -> rsp_err = 1, no write, rsp_rdata = 0, same latency.
REQ-030 Macro undefined: misaligned addresses are aligned down (half to addr[1], word to addr[1:0] = 0), rsp_err never set for misalignment.

Structure
REQ-031 Package mem_pkg holds the funct3 enum, the FSM state enum and the word/address width constants.
REQ-032 One sub-module mem_lane_align: combinational store byte-enable/data shifting and load extraction/extension.

Verification
REQ-033 READ_LATENCY=2: SW 0x8 data 0xDEADBEEF then LW 0x8 -> rsp_rdata 0xDEADBEEF, rsp_valid 2 cycles after acceptance, req_ready low 2 cycles.
REQ-034 After REQ-033: LB 0xB -> 0xFFFFFFDE; LBU 0xB -> 0x000000DE; LH 0x8 -> 0xFFFFBEEF; LHU 0xA -> 0x0000DEAD.
REQ-035 SB 0x9 data 0x12 over 0xDEADBEEF at 0x8, then LW 0x8 -> 0xDEAD12EF.
REQ-036 NUM_BLOCKS=128: LW 0x200 -> rsp_err 1, rsp_rdata 0; SW 0x200 -> rsp_err 1, array unchanged.
REQ-037 LW 0x6 with DMEM_MISALIGN_TRAP_EN -> rsp_err 1; without -> rsp_err 0, data of word 0x4.
REQ-038 rst low during WAIT of SW 0x10 data 0x55 -> rsp_valid never asserts, later LW 0x10 returns prior contents.
